trg_pls_sched: RTL and testbench

- Multi-channel trigger-pulse scheduler. An external SPI host configures it, and it drives the board TRG_PLS outputs.
- A built-in SPI receive front end decodes 24-bit command frames that set per-channel delay, per-channel width and the channel enable mask, and that FIRE or ABORT a sequence.
- On FIRE, each enabled channel waits its own delay and then emits one high pulse of its programmed width.
- Runs in the CLK50M domain beside ledpwm under the top level. It replaces the fixed-function trigger component with a programmable one.

---
 rtl/trg_pls_pkg.sv | 26 ++
 rtl/trg_pls_spi_rx.sv | 70 +++++++
 rtl/trg_pls_sched.sv | 162 ++++++++++++++++
 tb/tb_trg_pls_sched.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/trg_pls_pkg.sv
// Shared types and frame-field positions for the trigger-pulse scheduler.
package trg_pls_pkg;

  localparam int FRAME_W  = 24;
  localparam int OP_MSB   = 23;
  localparam int OP_LSB   = 20;
  localparam int CH_MSB   = 19;
  localparam int CH_LSB   = 16;
  localparam int DATA_MSB = 15;
  localparam int DATA_LSB = 0;

  typedef enum logic [3:0] {
    OP_SET_DELAY = 4'h1,
    OP_SET_WIDTH = 4'h2,
    OP_SET_MASK  = 4'h3,
    OP_FIRE      = 4'h4,
    OP_ABORT     = 4'h5
  } opcode_e;

  typedef enum logic [1:0] {
    CH_IDLE  = 2'd0,
    CH_DELAY = 2'd1,
    CH_PULSE = 2'd2
  } ch_state_e;

endpackage

// File: rtl/trg_pls_spi_rx.sv
// SPI mode-0 receive front end: synchronises the pins into the clock domain
// and emits a one-cycle strobe per well-formed 24-bit frame.
module trg_pls_spi_rx
  import trg_pls_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rstN,
  input  logic               i_spiCs,
  input  logic               i_spiClk,
  input  logic               i_spiMosi,
  output logic               o_cmdStb,
  output logic [FRAME_W-1:0] o_frame,
  output logic               o_frameErr
);

  logic [1:0]         r_csSync;
  logic [1:0]         r_sclkSync;
  logic [1:0]         r_mosiSync;
  logic               r_csPrev;
  logic               r_sclkPrev;
  logic [FRAME_W-1:0] r_shift;
  logic [4:0]         r_bitCnt;

  logic w_sclkRise;
  logic w_csFall;
  logic w_csRise;

  assign w_sclkRise = r_sclkSync[1] & ~r_sclkPrev;
  assign w_csFall   = ~r_csSync[1] & r_csPrev;
  assign w_csRise   = r_csSync[1] & ~r_csPrev;

  // CS flops reset high so that leaving reset never looks like a frame end.
  always_ff @(posedge i_clk or negedge i_rstN) begin
    if (!i_rstN) begin
      r_csSync   <= 2'b11;
      r_sclkSync <= 2'b00;
      r_mosiSync <= 2'b00;
      r_csPrev   <= 1'b1;
      r_sclkPrev <= 1'b0;
      r_shift    <= '0;
      r_bitCnt   <= '0;
      o_cmdStb   <= 1'b0;
      o_frame    <= '0;
      o_frameErr <= 1'b0;
    end else begin
      r_csSync   <= {r_csSync[0], i_spiCs};
      r_sclkSync <= {r_sclkSync[0], i_spiClk};
      r_mosiSync <= {r_mosiSync[0], i_spiMosi};
      r_csPrev   <= r_csSync[1];
      r_sclkPrev <= r_sclkSync[1];
      o_cmdStb   <= 1'b0;
      o_frameErr <= 1'b0;
      if (w_csFall) begin
        r_bitCnt <= '0;
      end else if (w_sclkRise && !r_csSync[1]) begin
        r_shift <= {r_shift[FRAME_W-2:0], r_mosiSync[1]};
        if (r_bitCnt != 5'd31) r_bitCnt <= r_bitCnt + 5'd1;
      end
      if (w_csRise) begin
        if (r_bitCnt == 5'(FRAME_W)) begin
          o_cmdStb <= 1'b1;
          o_frame  <= r_shift;
        end else begin
          o_frameErr <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/trg_pls_sched.sv
// Programmable multi-channel trigger-pulse scheduler configured over SPI;
// each enabled channel waits its delay after FIRE then pulses for its width.
module trg_pls_sched
  import trg_pls_pkg::*;
#(
  parameter int NUM_CH = 5,
  parameter int CNT_W  = 16
) (
  input  logic              CLK50M,
  input  logic              RESET_N,
  input  logic              SPI_CS,
  input  logic              SPI_CLK,
  input  logic              SPI_MOSI,
  output logic [NUM_CH-1:0] TRG_PLS,
  output logic              BUSY,
  output logic              FRAME_ERR
);

  logic               r_rstMeta;
  logic               r_rstSync;
  logic               w_rstN;
  logic               w_cmdStb;
  logic [FRAME_W-1:0] w_frame;
  logic [3:0]         w_opcode;
  logic [3:0]         w_ch;
  logic [15:0]        w_data;
  logic               w_fire;
  logic               w_abort;
  logic               w_setDelay;
  logic               w_setWidth;
  logic               w_setMask;
  logic [NUM_CH-1:0]  r_mask;
  logic [NUM_CH-1:0]  w_activeNext;
  logic               r_busy;

  // Reset asserts asynchronously but releases on a clock edge.
  always_ff @(posedge CLK50M or negedge RESET_N) begin
    if (!RESET_N) begin
      r_rstMeta <= 1'b0;
      r_rstSync <= 1'b0;
    end else begin
      r_rstMeta <= 1'b1;
      r_rstSync <= r_rstMeta;
    end
  end
  assign w_rstN = r_rstSync;

  trg_pls_spi_rx u_spiRx (
    .i_clk      (CLK50M),
    .i_rstN     (w_rstN),
    .i_spiCs    (SPI_CS),
    .i_spiClk   (SPI_CLK),
    .i_spiMosi  (SPI_MOSI),
    .o_cmdStb   (w_cmdStb),
    .o_frame    (w_frame),
    .o_frameErr (FRAME_ERR)
  );

  assign w_opcode   = w_frame[OP_MSB:OP_LSB];
  assign w_ch       = w_frame[CH_MSB:CH_LSB];
  assign w_data     = w_frame[DATA_MSB:DATA_LSB];
  assign w_setDelay = w_cmdStb && (w_opcode == OP_SET_DELAY);
  assign w_setWidth = w_cmdStb && (w_opcode == OP_SET_WIDTH);
  assign w_setMask  = w_cmdStb && (w_opcode == OP_SET_MASK);
  assign w_fire     = w_cmdStb && (w_opcode == OP_FIRE) && !r_busy;
  assign w_abort    = w_cmdStb && (w_opcode == OP_ABORT);

  always_ff @(posedge CLK50M or negedge w_rstN) begin
    if (!w_rstN) begin
      r_mask <= '0;
      r_busy <= 1'b0;
    end else begin
      if (w_setMask) r_mask <= w_data[NUM_CH-1:0];
      r_busy <= |w_activeNext;
    end
  end
  assign BUSY = r_busy;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [CNT_W-1:0] r_delay;
    logic [CNT_W-1:0] r_width;
    logic [CNT_W-1:0] r_shadowW;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cntNext;
    logic [CNT_W-1:0] w_shadowNext;
    ch_state_e        r_state;
    ch_state_e        w_stateNext;
    logic             r_pls;
    logic             w_chSel;
    logic             w_eligible;

    assign w_chSel    = (w_ch == 4'(gi));
    assign w_eligible = r_mask[gi] && (r_width != '0);

    always_ff @(posedge CLK50M or negedge w_rstN) begin
      if (!w_rstN) begin
        r_delay <= '0;
        r_width <= '0;
      end else begin
        if (w_setDelay && w_chSel) r_delay <= w_data[CNT_W-1:0];
        if (w_setWidth && w_chSel) r_width <= w_data[CNT_W-1:0];
      end
    end

    always_ff @(posedge CLK50M or negedge w_rstN) begin
      if (!w_rstN) begin
        r_state   <= CH_IDLE;
        r_cnt     <= '0;
        r_shadowW <= '0;
        r_pls     <= 1'b0;
      end else begin
        r_state   <= w_stateNext;
        r_cnt     <= w_cntNext;
        r_shadowW <= w_shadowNext;
        r_pls     <= (w_stateNext == CH_PULSE);
      end
    end

    // The running sequence only ever reads the shadow width, so SET_WIDTH
    // during a sequence takes effect on the next FIRE.
    always_comb begin
      w_stateNext  = r_state;
      w_cntNext    = r_cnt;
      w_shadowNext = r_shadowW;
      case (r_state)
        CH_IDLE: begin
          if (w_fire && w_eligible) begin
            w_shadowNext = r_width;
            if (r_delay != '0) begin
              w_stateNext = CH_DELAY;
              w_cntNext   = r_delay - CNT_W'(1);
            end else begin
              w_stateNext = CH_PULSE;
              w_cntNext   = r_width - CNT_W'(1);
            end
          end
        end
        CH_DELAY: begin
          if (r_cnt == '0) begin
            w_stateNext = CH_PULSE;
            w_cntNext   = r_shadowW - CNT_W'(1);
          end else begin
            w_cntNext = r_cnt - CNT_W'(1);
          end
        end
        CH_PULSE: begin
          if (r_cnt == '0) begin
            w_stateNext = CH_IDLE;
          end else begin
            w_cntNext = r_cnt - CNT_W'(1);
          end
        end
        default: w_stateNext = CH_IDLE;
      endcase
      if (w_abort) w_stateNext = CH_IDLE;
    end

    assign w_activeNext[gi] = (w_stateNext != CH_IDLE);
    assign TRG_PLS[gi]      = r_pls;
  end

endmodule

// File: tb/tb_trg_pls_sched.sv
// Self-checking bench for trg_pls_sched: drives SPI frames and compares the
// outputs every cycle against a window-based model of the pulse schedule.
module tb_trg_pls_sched;

  localparam int NUM_CH = 5;

  logic              CLK50M   = 1'b0;
  logic              RESET_N  = 1'b0;
  logic              SPI_CS   = 1'b1;
  logic              SPI_CLK  = 1'b0;
  logic              SPI_MOSI = 1'b0;
  logic [NUM_CH-1:0] TRG_PLS;
  logic              BUSY;
  logic              FRAME_ERR;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int mDelay [NUM_CH];
  int mWidth [NUM_CH];
  int mMask;
  int pStart [NUM_CH];
  int pEnd   [NUM_CH];
  int bStart;
  int bEnd;
  int expErrCyc;
  int csRise;
  int lastT;
  bit compareEn = 1'b0;
  logic [NUM_CH-1:0] expVec;

  trg_pls_sched #(.NUM_CH(NUM_CH), .CNT_W(16)) u_dut (
    .CLK50M    (CLK50M),
    .RESET_N   (RESET_N),
    .SPI_CS    (SPI_CS),
    .SPI_CLK   (SPI_CLK),
    .SPI_MOSI  (SPI_MOSI),
    .TRG_PLS   (TRG_PLS),
    .BUSY      (BUSY),
    .FRAME_ERR (FRAME_ERR)
  );

  always #10 CLK50M = ~CLK50M;

  always @(posedge CLK50M) cyc <= cyc + 1;

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Model: each channel owns one pulse window [pStart, pEnd] in cycle numbers.
  task automatic modelReset();
    for (int i = 0; i < NUM_CH; i++) begin
      mDelay[i] = 0;
      mWidth[i] = 0;
      pStart[i] = 1;
      pEnd[i]   = 0;
    end
    mMask     = 0;
    bStart    = 1;
    bEnd      = 0;
    expErrCyc = -1;
  endtask

  always @(negedge CLK50M) begin
    if (compareEn) begin
      expVec = '0;
      for (int i = 0; i < NUM_CH; i++)
        expVec[i] = (cyc >= pStart[i]) && (cyc <= pEnd[i]);
      checkOutput("trg_pls", 32'(TRG_PLS), 32'(expVec));
      checkOutput("busy", 32'(BUSY), 32'((cyc >= bStart) && (cyc <= bEnd)));
      checkOutput("frame_err", 32'(FRAME_ERR), 32'(cyc == expErrCyc));
    end
  end

  task automatic waitCycle(input int c);
    while (cyc < c) @(negedge CLK50M);
  endtask

  // SPI clock is CLK50M/8; all pin changes happen on a CLK50M falling edge,
  // so cmd_stb lands exactly 3 cycles after the CS rise.
  task automatic sendRaw(input logic [31:0] bits, input int n);
    repeat (6) @(negedge CLK50M);
    SPI_CS = 1'b0;
    repeat (4) @(negedge CLK50M);
    for (int b = n - 1; b >= 0; b--) begin
      SPI_MOSI = bits[b];
      repeat (4) @(negedge CLK50M);
      SPI_CLK = 1'b1;
      repeat (4) @(negedge CLK50M);
      SPI_CLK = 1'b0;
    end
    repeat (4) @(negedge CLK50M);
    SPI_CS = 1'b1;
    csRise = cyc;
  endtask

  task automatic sendBad(input logic [31:0] bits, input int n);
    sendRaw(bits, n);
    expErrCyc = csRise + 3;
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [3:0] ch, input logic [15:0] data);
    int t;
    int mx;
    sendRaw({8'h00, op, ch, data}, 24);
    t = csRise + 3;
    lastT = t;
    case (op)
      4'h1: if (int'(ch) < NUM_CH) mDelay[ch] = int'(data);
      4'h2: if (int'(ch) < NUM_CH) mWidth[ch] = int'(data);
      4'h3: mMask = int'(data) & ((1 << NUM_CH) - 1);
      4'h4: begin
        if (!((t >= bStart) && (t <= bEnd))) begin
          mx = 0;
          for (int i = 0; i < NUM_CH; i++) begin
            if (mMask[i] && (mWidth[i] != 0)) begin
              pStart[i] = t + 1 + mDelay[i];
              pEnd[i]   = t + mDelay[i] + mWidth[i];
              if (pEnd[i] > mx) mx = pEnd[i];
            end else begin
              pStart[i] = 1;
              pEnd[i]   = 0;
            end
          end
          if (mx > 0) begin
            bStart = t + 1;
            bEnd   = mx;
          end
        end
      end
      4'h5: begin
        for (int i = 0; i < NUM_CH; i++)
          if (pEnd[i] > t) pEnd[i] = t;
        if (bEnd > t) bEnd = t;
      end
      default: ;
    endcase
  endtask

  initial begin
    int t;
    int t1;
    modelReset();
    RESET_N = 1'b0;
    repeat (5) @(negedge CLK50M);
    RESET_N = 1'b1;
    compareEn = 1'b1;
    checkOutput("reset_trg", 32'(TRG_PLS), 32'd0);
    checkOutput("reset_busy", 32'(BUSY), 32'd0);
    checkOutput("reset_ferr", 32'(FRAME_ERR), 32'd0);
    repeat (1000) @(negedge CLK50M);

    $display("[TB] two-channel sequence");
    applyStimulus(4'h1, 4'd0, 16'd10);
    applyStimulus(4'h2, 4'd0, 16'd5);
    applyStimulus(4'h1, 4'd3, 16'd0);
    applyStimulus(4'h2, 4'd3, 16'd3);
    applyStimulus(4'h1, 4'd8, 16'd3);
    applyStimulus(4'h3, 4'd0, 16'h0009);
    applyStimulus(4'h4, 4'd0, 16'd0);
    t = lastT;
    waitCycle(t + 1);  checkOutput("seq1_t1", 32'(TRG_PLS), 32'h08);
    checkOutput("seq1_busy_t1", 32'(BUSY), 32'd1);
    waitCycle(t + 3);  checkOutput("seq1_t3", 32'(TRG_PLS), 32'h08);
    waitCycle(t + 4);  checkOutput("seq1_t4", 32'(TRG_PLS), 32'h00);
    waitCycle(t + 11); checkOutput("seq1_t11", 32'(TRG_PLS), 32'h01);
    waitCycle(t + 15); checkOutput("seq1_t15", 32'(TRG_PLS), 32'h01);
    checkOutput("seq1_busy_t15", 32'(BUSY), 32'd1);
    waitCycle(t + 16); checkOutput("seq1_t16", 32'(TRG_PLS), 32'h00);
    checkOutput("seq1_busy_t16", 32'(BUSY), 32'd0);

    $display("[TB] abort during delay");
    applyStimulus(4'h1, 4'd1, 16'd1000);
    applyStimulus(4'h2, 4'd1, 16'd100);
    applyStimulus(4'h3, 4'd0, 16'h0002);
    applyStimulus(4'h4, 4'd0, 16'd0);
    t = lastT;
    waitCycle(t + 280);
    applyStimulus(4'h5, 4'd0, 16'd0);
    t1 = lastT;
    waitCycle(t1);     checkOutput("abort_busy_t", 32'(BUSY), 32'd1);
    waitCycle(t1 + 1); checkOutput("abort_busy_t1", 32'(BUSY), 32'd0);
    waitCycle(t + 1200);

    $display("[TB] reconfigure and refire while busy");
    applyStimulus(4'h4, 4'd0, 16'd0);
    t = lastT;
    applyStimulus(4'h2, 4'd1, 16'd50);
    applyStimulus(4'h4, 4'd0, 16'd0);
    waitCycle(t + 1000); checkOutput("busy_old_t1000", 32'(TRG_PLS), 32'h00);
    waitCycle(t + 1001); checkOutput("busy_old_t1001", 32'(TRG_PLS), 32'h02);
    waitCycle(t + 1100); checkOutput("busy_old_t1100", 32'(TRG_PLS), 32'h02);
    waitCycle(t + 1101); checkOutput("busy_old_t1101", 32'(TRG_PLS), 32'h00);
    checkOutput("busy_old_busy", 32'(BUSY), 32'd0);
    applyStimulus(4'h4, 4'd0, 16'd0);
    t = lastT;
    waitCycle(t + 1050); checkOutput("new_w_t1050", 32'(TRG_PLS), 32'h02);
    waitCycle(t + 1051); checkOutput("new_w_t1051", 32'(TRG_PLS), 32'h00);

    $display("[TB] short and long frames");
    sendBad(32'h0011_0003, 23);
    waitCycle(expErrCyc); checkOutput("ferr_23", 32'(FRAME_ERR), 32'd1);
    sendBad(32'h0021_0005, 25);
    waitCycle(expErrCyc); checkOutput("ferr_25", 32'(FRAME_ERR), 32'd1);
    applyStimulus(4'h4, 4'd0, 16'd0);
    t = lastT;
    waitCycle(t + 1050); checkOutput("after_err_t1050", 32'(TRG_PLS), 32'h02);
    waitCycle(t + 1051); checkOutput("after_err_t1051", 32'(TRG_PLS), 32'h00);

    $display("[TB] zero width and unknown opcode");
    applyStimulus(4'h3, 4'd0, 16'h0004);
    applyStimulus(4'h2, 4'd2, 16'd0);
    applyStimulus(4'h4, 4'd0, 16'd0);
    t = lastT;
    waitCycle(t + 2); checkOutput("nop_fire_busy", 32'(BUSY), 32'd0);
    applyStimulus(4'h3, 4'd0, 16'h0006);
    applyStimulus(4'hF, 4'd1, 16'h001F);
    applyStimulus(4'h4, 4'd0, 16'd0);
    t = lastT;
    waitCycle(t + 1);    checkOutput("w0_busy", 32'(BUSY), 32'd1);
    waitCycle(t + 1001); checkOutput("w0_t1001", 32'(TRG_PLS), 32'h02);
    waitCycle(t + 1052); checkOutput("w0_done", 32'(BUSY), 32'd0);

    $display("[TB] reset mid-pulse");
    applyStimulus(4'h4, 4'd0, 16'd0);
    t = lastT;
    waitCycle(t + 1010); checkOutput("pre_rst_pls", 32'(TRG_PLS), 32'h02);
    #3;
    RESET_N = 1'b0;
    modelReset();
    #1;
    checkOutput("rst_async_trg", 32'(TRG_PLS), 32'h00);
    checkOutput("rst_async_busy", 32'(BUSY), 32'd0);
    repeat (3) @(negedge CLK50M);
    RESET_N = 1'b1;
    repeat (10) @(negedge CLK50M);
    applyStimulus(4'h4, 4'd0, 16'd0);
    t = lastT;
    waitCycle(t + 1); checkOutput("post_rst_busy", 32'(BUSY), 32'd0);
    repeat (20) @(negedge CLK50M);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
